fp_conv_pipe: RTL and testbench

Pipelined, handshaked IEEE-754-style format converter between two arbitrary `(exponent, mantissa)` widths. Adds special-value handling, overflow/underflow saturation, exception flags and optional round-to-nearest-even when narrowing. Sits between FP datapath stages of differing precision, for example double-to-single ahead of a narrow multiplier. Input and output are valid/ready streams with a fixed two-cycle latency.

---
 rtl/fp_conv_pipe.sv | 173 +++++++++++++++++
 tb/tb_fp_conv_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_conv_pipe.sv
// fp_conv_pipe: two-stage valid/ready floating-point format converter.
//   Converts {sign, exp[INX], mant[INM]} to {sign, exp[ONX], mant[ONM]} with
//   special-value handling, overflow/underflow saturation (DAZ/FTZ) and flags.
//   Optional build macro: FP_CONV_RNE_EN -> round-to-nearest-even when the
//   mantissa narrows; otherwise narrowing truncates toward zero.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready/in_v      input stream (in_ready is combinational)
//   out_valid/out_ready/out_v   output stream (registered)
//   out_flags       {invalid, overflow, underflow, inexact}, aligned with out_v
module fp_conv_pipe #(
   parameter int unsigned INX = 11,
   parameter int unsigned INM = 52,
   parameter int unsigned ONX = 8,
   parameter int unsigned ONM = 23
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [INX+INM:0]     in_v,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ONX+ONM:0]     out_v,
   output logic [3:0]           out_flags
);

   // Exponent arithmetic width: wide enough to hold any rebiased value signed.
   localparam int unsigned EW    = ((INX > ONX) ? INX : ONX) + 2;
   // Alignment width: holds the kept mantissa plus at least guard and sticky bits.
   localparam int unsigned XW    = (INM > ONM + 2) ? INM : ONM + 2;
   localparam int unsigned IXOFF = (1 << (INX - 1)) - 1;
   localparam int unsigned OXOFF = (1 << (ONX - 1)) - 1;
   localparam int unsigned E_MAX = (1 << ONX) - 1;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_INF  = 2'd1,
      CLS_NAN  = 2'd2,
      CLS_NORM = 2'd3
   } cls_t;

   logic              w_adv;
   logic              w_sign;
   logic [INX-1:0]    w_exp;
   logic [INM-1:0]    w_mant;
   logic [XW-1:0]     w_al;
   logic [EW-1:0]     w_e;
   cls_t              w_cls;

   logic              r1_valid;
   logic              r1_sign;
   cls_t              r1_cls;
   logic              r1_snan;
   logic [EW-1:0]     r1_e;
   logic [ONM-1:0]    r1_mant;
   logic              r1_guard;
   logic              r1_sticky;

   logic              w_round_up;
   logic [ONM:0]      w_sum;
   logic [EW-1:0]     w_e_r;
   logic              w_ovf;
   logic              w_unf;
   logic              w_inexact;
   logic [ONX+ONM:0]  w_res;
   logic [3:0]        w_flags;

   // Single stall condition shared by both stages.
   assign w_adv    = !out_valid || out_ready;
   assign in_ready = w_adv;

   // Input field split, mantissa left-aligned so truncation/guard/sticky fall out by slicing.
   assign w_sign = in_v[INX+INM];
   assign w_exp  = in_v[INM +: INX];
   assign w_mant = in_v[INM-1:0];
   assign w_al   = XW'(w_mant) << (XW - INM);
   // Rebias modulo 2^EW; the MSB acts as the sign of the result.
   assign w_e    = EW'(w_exp) + EW'(OXOFF) - EW'(IXOFF);

   // Input classification.
   always_comb begin
      w_cls = CLS_NORM;
      if (w_exp == '0) begin
         w_cls = CLS_ZERO;
      end else if (&w_exp) begin
         w_cls = (w_mant == '0) ? CLS_INF : CLS_NAN;
      end
   end

   // Stage 1 register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r1_valid  <= 1'b0;
         r1_sign   <= 1'b0;
         r1_cls    <= CLS_ZERO;
         r1_snan   <= 1'b0;
         r1_e      <= '0;
         r1_mant   <= '0;
         r1_guard  <= 1'b0;
         r1_sticky <= 1'b0;
      end else if (w_adv) begin
         r1_valid <= in_valid;
         if (in_valid) begin
            r1_sign   <= w_sign;
            r1_cls    <= w_cls;
            r1_snan   <= !w_mant[INM-1];
            r1_e      <= w_e;
            r1_mant   <= w_al[XW-1 -: ONM];
            r1_guard  <= w_al[XW-ONM-1];
            r1_sticky <= |w_al[XW-ONM-2:0];
         end
      end
   end

   // Rounding decision.
   always_comb begin
`ifdef FP_CONV_RNE_EN
      w_round_up = r1_guard && (r1_sticky || r1_mant[0]);
`else
      w_round_up = 1'b0;
`endif
   end

   // A carry out of the mantissa leaves the low bits zero and bumps the exponent.
   assign w_sum     = {1'b0, r1_mant} + (ONM+1)'(w_round_up);
   assign w_e_r     = r1_e + EW'(w_sum[ONM]);
   assign w_ovf     = !w_e_r[EW-1] && (w_e_r >= EW'(E_MAX));
   assign w_unf     = w_e_r[EW-1] || (w_e_r == '0);
   assign w_inexact = r1_guard || r1_sticky;

   // Range check, packing and flags.
   always_comb begin
      w_res   = '0;
      w_flags = '0;
      case (r1_cls)
         CLS_ZERO: w_res = {r1_sign, {(ONX+ONM){1'b0}}};
         CLS_INF:  w_res = {r1_sign, {ONX{1'b1}}, {ONM{1'b0}}};
         CLS_NAN: begin
            w_res   = {r1_sign, {ONX{1'b1}}, 1'b1, {(ONM-1){1'b0}}};
            w_flags = {r1_snan, 3'b000};
         end
         default: begin
            if (w_ovf) begin
               w_res   = {r1_sign, {ONX{1'b1}}, {ONM{1'b0}}};
               w_flags = 4'b0101;
            end else if (w_unf) begin
               w_res   = {r1_sign, {(ONX+ONM){1'b0}}};
               w_flags = 4'b0011;
            end else begin
               w_res   = {r1_sign, w_e_r[ONX-1:0], w_sum[ONM-1:0]};
               w_flags = {3'b000, w_inexact};
            end
         end
      endcase
   end

   // Stage 2 register drives the output port directly.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_v     <= '0;
         out_flags <= '0;
      end else if (w_adv) begin
         out_valid <= r1_valid;
         if (r1_valid) begin
            out_v     <= w_res;
            out_flags <= w_flags;
         end
      end
   end

endmodule

// File: tb/tb_fp_conv_pipe.sv
// tb_fp_conv_pipe: directed and randomized bench for fp_conv_pipe.
//   u_narrow: double -> single (default parameters), stream with backpressure.
//   u_wide:   single -> double, directed and random single words.
//   Build macro FP_CONV_RNE_EN selects the rounding mode expected by the model.
module tb_fp_conv_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_v;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_v;
   logic [3:0]  out_flags;

   logic        w_in_valid;
   logic        w_in_ready;
   logic [31:0] w_in_v;
   logic        w_out_valid;
   logic        w_out_ready;
   logic [63:0] w_out_v;
   logic [3:0]  w_out_flags;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [35:0] exp_q[$];
   logic        force_const = 1'b0;
   logic [35:0] const_word  = '0;
   logic        hold_valid  = 1'b0;
   logic [35:0] hold_word   = '0;
   logic        last_acc    = 1'b0;

   always #5 clk = ~clk;

   fp_conv_pipe u_narrow (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_v      (in_v),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_v     (out_v),
      .out_flags (out_flags)
   );

   fp_conv_pipe #(.INX(8), .INM(23), .ONX(11), .ONM(52)) u_wide (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (w_in_valid),
      .in_ready  (w_in_ready),
      .in_v      (w_in_v),
      .out_valid (w_out_valid),
      .out_ready (w_out_ready),
      .out_v     (w_out_v),
      .out_flags (w_out_flags)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference conversion by value: integer significand, unbiased exponent,
   // remainder-vs-half rounding. Returns {flags, word}.
   function automatic logic [67:0] ref_conv(input int inx, input int inm, input int onx,
                                            input int onm, input logic [63:0] x);
      logic [63:0] one, mant, sig, q, rem, v, sbits;
      logic        sign, inexact, up;
      int          ex, e, b, ones;
      logic [3:0]  f;
      one   = 64'd1;
      sign  = x[inx+inm];
      ex    = int'((x >> inm) & ((one << inx) - one));
      mant  = x & ((one << inm) - one);
      ones  = (1 << onx) - 1;
      sbits = 64'(sign) << (onx + onm);
      v     = sbits;
      f     = 4'b0000;
      if (ex == 0) begin
         v = sbits;
      end else if (ex == (1 << inx) - 1) begin
         v = sbits | (64'(ones) << onm);
         if (mant != 64'd0) begin
            v = v | (one << (onm - 1));
            f = mant[inm-1] ? 4'b0000 : 4'b1000;
         end
      end else begin
         e   = ex - ((1 << (inx - 1)) - 1);
         sig = mant | (one << inm);
         up  = 1'b0;
         if (onm >= inm) begin
            q   = sig << (onm - inm);
            rem = 64'd0;
         end else begin
            q   = sig >> (inm - onm);
            rem = sig & ((one << (inm - onm)) - one);
`ifdef FP_CONV_RNE_EN
            up  = (rem > (one << (inm - onm - 1))) ||
                  ((rem == (one << (inm - onm - 1))) && q[0]);
`endif
         end
         inexact = (rem != 64'd0);
         q = q + 64'(up);
         if (q == (one << (onm + 1))) begin
            q = q >> 1;
            e = e + 1;
         end
         b = e + ((1 << (onx - 1)) - 1);
         if (b >= ones) begin
            v = sbits | (64'(ones) << onm);
            f = 4'b0101;
         end else if (b <= 0) begin
            v = sbits;
            f = 4'b0011;
         end else begin
            v = sbits | (64'(b) << onm) | (q & ((one << onm) - one));
            f = {3'b000, inexact};
         end
      end
      return {f, v};
   endfunction

   function automatic logic [63:0] rand_d();
      logic [51:0] m;
      logic [10:0] e;
      int          sel;
      m   = 52'({$urandom, $urandom});
      e   = 11'($urandom_range(1023 - 140, 1023 + 140));
      sel = int'($urandom_range(0, 9));
      if (sel == 0) e = 11'd0;
      if (sel == 1) begin
         e = 11'h7FF;
         if ($urandom_range(0, 1) == 0) m = 52'd0;
      end
      if (sel == 2) m[28:0] = 29'h1000_0000;
      if (sel == 3) m[28:0] = 29'd0;
      return {1'($urandom_range(0, 1)), e, m};
   endfunction

   // One cycle on the narrow converter: drive, check port rules, score transfers, clock.
   task automatic cycle(input logic iv, input logic [63:0] d, input logic ordy);
      logic [67:0] r;
      logic [35:0] e;
      in_valid  = iv;
      in_v      = d;
      out_ready = ordy;
      #1;
      check("in_ready", 64'(in_ready), 64'(!out_valid || ordy));
      if (out_valid && hold_valid)
         check("stall_hold", 64'({out_flags, out_v}), 64'(hold_word));
      if (out_valid && ordy) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_v", 64'(out_v), 64'(e[31:0]));
            check("out_flags", 64'(out_flags), 64'(e[35:32]));
         end
      end
      hold_valid = out_valid && !ordy;
      hold_word  = {out_flags, out_v};
      last_acc   = iv && in_ready;
      if (last_acc) begin
         r = ref_conv(11, 52, 8, 23, d);
         exp_q.push_back(force_const ? const_word : {r[67:64], r[31:0]});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic directed(input logic [63:0] d, input logic [31:0] ev, input logic [3:0] ef);
      force_const = 1'b1;
      const_word  = {ef, ev};
      cycle(1'b1, d, 1'b1);
      force_const = 1'b0;
      cycle(1'b0, 64'd0, 1'b1);
      cycle(1'b0, 64'd0, 1'b1);
   endtask

   task automatic wide_one(input string tag, input logic [31:0] d,
                           input logic [63:0] ev, input logic [3:0] ef);
      w_in_valid = 1'b1;
      w_in_v     = d;
      @(posedge clk);
      @(negedge clk);
      w_in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_valid"}, 64'(w_out_valid), 64'd1);
      check({tag, "_v"}, w_out_v, ev);
      check({tag, "_flags"}, 64'(w_out_flags), 64'(ef));
   endtask

   task automatic run_stream(input int n);
      logic [63:0] word;
      word = rand_d();
      for (int i = 0; i < n; i++) begin
         cycle(1'b1, word, 1'($urandom_range(0, 2) != 0));
         if (last_acc) word = rand_d();
      end
   endtask

   initial begin
      logic [67:0] r;
      logic [31:0] s;
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_v        = '0;
      out_ready   = 1'b0;
      w_in_valid  = 1'b0;
      w_in_v      = '0;
      w_out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_v", 64'(out_v), 64'd0);
      check("rst_out_flags", 64'(out_flags), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);

      // 1.0 with latency check: not valid after one edge, valid after two.
      force_const = 1'b1;
      const_word  = {4'b0000, 32'h3F80_0000};
      cycle(1'b1, 64'h3FF0_0000_0000_0000, 1'b1);
      force_const = 1'b0;
      check("lat_edge1", 64'(out_valid), 64'd0);
      cycle(1'b0, 64'd0, 1'b1);
      check("lat_edge2", 64'(out_valid), 64'd1);
      cycle(1'b0, 64'd0, 1'b1);

      directed(64'h3FF0_0000_1000_0000, 32'h3F80_0000, 4'b0001);
`ifdef FP_CONV_RNE_EN
      directed(64'h3FF0_0000_3000_0000, 32'h3F80_0002, 4'b0001);
`else
      directed(64'h3FF0_0000_3000_0000, 32'h3F80_0001, 4'b0001);
`endif
      directed(64'h7FE0_0000_0000_0000, 32'h7F80_0000, 4'b0101);
      directed(64'h3800_0000_0000_0000, 32'h0000_0000, 4'b0011);
      directed(64'h7FF0_0000_0000_0001, 32'h7FC0_0000, 4'b1000);
      directed(64'hFFF0_0000_0000_0000, 32'hFF80_0000, 4'b0000);
      directed(64'h8000_0000_0000_0005, 32'h8000_0000, 4'b0000);
      directed(64'h7FF8_0000_0000_0000, 32'h7FC0_0000, 4'b0000);

      wide_one("w_one", 32'h3F80_0000, 64'h3FF0_0000_0000_0000, 4'b0000);
      wide_one("w_pi", 32'hC049_0FDB, 64'hC009_21FB_6000_0000, 4'b0000);
      for (int i = 0; i < 10; i++) begin
         s = $urandom;
         r = ref_conv(8, 23, 11, 52, {32'd0, s});
         wide_one("w_rand", s, r[63:0], r[67:64]);
      end

      // Randomized stream under toggling backpressure.
      run_stream(30);

      // Reset mid-stream: in-flight words are discarded.
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      hold_valid = 1'b0;
      check("midrst_out_valid", 64'(out_valid), 64'd0);

      run_stream(40);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++)
         cycle(1'b0, 64'd0, 1'b1);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
      for (int i = 0; i < 3; i++)
         cycle(1'b0, 64'd0, 1'b1);
      check("end_out_valid", 64'(out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
